// File: rtl/store_buffer_if.sv
// Store-port / memory-port / forwarding bundle for store_buffer.
// slave = buffer side, master = core/memory side.
interface store_buffer_if #(
    parameter int WIDTH    = 32,
    parameter int ADDRSIZE = 8
);
    logic                cpu_we;
    logic [ADDRSIZE-1:0] cpu_addr;
    logic [WIDTH-1:0]    cpu_wdata;
    logic                cpu_full;
    logic                overflow;
    logic                empty;
    logic                mem_valid;
    logic                mem_ready;
    logic [ADDRSIZE-1:0] mem_addr;
    logic [WIDTH-1:0]    mem_wdata;
    logic [ADDRSIZE-1:0] fwd_addr;
    logic                fwd_hit;
    logic [WIDTH-1:0]    fwd_data;

    modport slave (
        input  cpu_we, cpu_addr, cpu_wdata, mem_ready, fwd_addr,
        output cpu_full, overflow, empty, mem_valid, mem_addr, mem_wdata,
               fwd_hit, fwd_data
    );

    modport master (
        output cpu_we, cpu_addr, cpu_wdata, mem_ready, fwd_addr,
        input  cpu_full, overflow, empty, mem_valid, mem_addr, mem_wdata,
               fwd_hit, fwd_data
    );
endinterface

// File: rtl/store_buffer.sv
// Posted-write FIFO between the core store port and data memory.
// Define STORE_BUF_FWD_EN to compile in store-to-load forwarding.
module store_buffer #(
    parameter int WIDTH    = 32,
    parameter int ADDRSIZE = 8,
    parameter int DEPTH    = 4
) (
    input  logic           clk,
    input  logic           nrst,
    store_buffer_if.slave  sb_io
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [ADDRSIZE-1:0] addr_q [DEPTH];
    logic [WIDTH-1:0]    data_q [DEPTH];
    logic [PW-1:0]       wp_q, wp_d;
    logic [PW-1:0]       rp_q, rp_d;
    logic [PW:0]         cnt_q, cnt_d;
    logic                ovf_q, ovf_d;
    logic                full;
    logic                push;
    logic                pop;

    // Full is judged on the current count only, so a same-cycle pop never rescues a push.
    always_comb begin
        full  = (cnt_q == FULL_CNT);
        push  = sb_io.cpu_we && !full;
        pop   = (cnt_q != '0) && sb_io.mem_ready;
        wp_d  = push ? wp_q + 1'b1 : wp_q;
        rp_d  = pop  ? rp_q + 1'b1 : rp_q;
        cnt_d = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!push && pop) begin
            cnt_d = cnt_q - 1'b1;
        end
        ovf_d = ovf_q | (sb_io.cpu_we & full);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            if (push) begin
                addr_q[wp_q] <= sb_io.cpu_addr;
                data_q[wp_q] <= sb_io.cpu_wdata;
            end
        end
    end

    assign sb_io.cpu_full  = full;
    assign sb_io.empty     = (cnt_q == '0);
    assign sb_io.mem_valid = (cnt_q != '0);
    assign sb_io.overflow  = ovf_q;
    assign sb_io.mem_addr  = addr_q[rp_q];
    assign sb_io.mem_wdata = data_q[rp_q];

`ifdef STORE_BUF_FWD_EN
    logic             fwd_hit_c;
    logic [WIDTH-1:0] fwd_data_c;
    logic [PW-1:0]    idx;

    // Walk oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        fwd_hit_c  = 1'b0;
        fwd_data_c = '0;
        idx        = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = rp_q + PW'(i);
            if (((PW+1)'(i) < cnt_q) && (addr_q[idx] == sb_io.fwd_addr)) begin
                fwd_hit_c  = 1'b1;
                fwd_data_c = data_q[idx];
            end
        end
    end

    assign sb_io.fwd_hit  = fwd_hit_c;
    assign sb_io.fwd_data = fwd_data_c;
`else
    logic unused_fwd_addr;

    assign unused_fwd_addr = ^sb_io.fwd_addr;
    assign sb_io.fwd_hit   = 1'b0;
    assign sb_io.fwd_data  = '0;
`endif
endmodule

// File: tb/tb_store_buffer.sv
// Randomized and directed self-checking bench for store_buffer against a queue model.
module tb_store_buffer;
    localparam int W = 32;
    localparam int A = 8;
    localparam int D = 4;

    typedef struct {
        logic [A-1:0] addr;
        logic [W-1:0] data;
    } ent_t;

    logic clk  = 1'b0;
    logic nrst = 1'b0;

    store_buffer_if #(.WIDTH(W), .ADDRSIZE(A)) sb_if ();

    store_buffer #(.WIDTH(W), .ADDRSIZE(A), .DEPTH(D)) dut (
        .clk   (clk),
        .nrst  (nrst),
        .sb_io (sb_if)
    );

    always #5 clk = ~clk;

    ent_t q[$];
    bit   m_ovf;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Drive one cycle of inputs, advance the model, then land at the next negedge.
    task automatic cycle(input logic we, input logic [A-1:0] a, input logic [W-1:0] d,
                         input logic rdy);
        bit   pop;
        bit   push;
        ent_t e;
        sb_if.cpu_we    = we;
        sb_if.cpu_addr  = a;
        sb_if.cpu_wdata = d;
        sb_if.mem_ready = rdy;
        pop  = (q.size() != 0) && rdy;
        push = we && (q.size() < D);
        if (we && q.size() == D) m_ovf = 1'b1;
        if (pop) void'(q.pop_front());
        if (push) begin
            e.addr = a;
            e.data = d;
            q.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        sb_if.cpu_we    = 1'b0;
        sb_if.cpu_addr  = '0;
        sb_if.cpu_wdata = '0;
        sb_if.mem_ready = 1'b0;
        sb_if.fwd_addr  = '0;
        nrst = 1'b0;
        q.delete();
        m_ovf = 1'b0;
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (sb_if.empty !== 1'b1) begin n_fail++; $display("FAIL rst_empty got=%b exp=1", sb_if.empty); end
        n_checks++; if (sb_if.mem_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got=%b exp=0", sb_if.mem_valid); end
        for (int i = 0; i < 3; i++) cycle(1'b1, A'(8'h50 + i), W'(32'h77 + i), 1'b0);
        n_checks++; if (sb_if.empty !== 1'b0) begin n_fail++; $display("FAIL rst_prefill_empty got=%b exp=0", sb_if.empty); end
        #2 nrst = 1'b0;
        #1;
        n_checks++; if (sb_if.empty !== 1'b1) begin n_fail++; $display("FAIL rst_async_empty got=%b exp=1", sb_if.empty); end
        n_checks++; if (sb_if.mem_valid !== 1'b0) begin n_fail++; $display("FAIL rst_async_valid got=%b exp=0", sb_if.mem_valid); end
        n_checks++; if (sb_if.cpu_full !== 1'b0) begin n_fail++; $display("FAIL rst_async_full got=%b exp=0", sb_if.cpu_full); end
        n_checks++; if (sb_if.overflow !== 1'b0) begin n_fail++; $display("FAIL rst_async_ovf got=%b exp=0", sb_if.overflow); end
        n_checks++; if (sb_if.mem_addr !== '0) begin n_fail++; $display("FAIL rst_async_addr got=%h exp=0", sb_if.mem_addr); end
        n_checks++; if (sb_if.mem_wdata !== '0) begin n_fail++; $display("FAIL rst_async_wdata got=%h exp=0", sb_if.mem_wdata); end
        n_checks++; if (sb_if.fwd_hit !== 1'b0 || sb_if.fwd_data !== '0) begin n_fail++; $display("FAIL rst_async_fwd got=%b/%h exp=0/0", sb_if.fwd_hit, sb_if.fwd_data); end
        sb_if.cpu_we    = 1'b1;
        sb_if.mem_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            n_checks++; if (sb_if.mem_valid !== 1'b0) begin n_fail++; $display("FAIL rst_hold_valid got=%b exp=0", sb_if.mem_valid); end
        end
        do_reset();
    endtask

    task automatic test_fill_drain();
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, A'(8'h10 + i), W'(32'hA + i), 1'b0);
        n_checks++; if (sb_if.cpu_full !== 1'b1) begin n_fail++; $display("FAIL fill_full got=%b exp=1", sb_if.cpu_full); end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (sb_if.mem_valid !== 1'b1 || sb_if.mem_addr !== A'(8'h10 + i) || sb_if.mem_wdata !== W'(32'hA + i)) begin
                n_fail++; $display("FAIL drain_%0d got=%b/%h/%h exp=1/%h/%h", i, sb_if.mem_valid, sb_if.mem_addr, sb_if.mem_wdata, A'(8'h10 + i), W'(32'hA + i));
            end
            cycle(1'b0, '0, '0, 1'b1);
        end
        n_checks++; if (sb_if.empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty got=%b exp=1", sb_if.empty); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, A'(8'h10 + i), W'(32'hA + i), 1'b0);
        cycle(1'b1, 8'h20, 32'hFF, 1'b1);
        n_checks++; if (sb_if.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set got=%b exp=1", sb_if.overflow); end
        n_checks++; if (sb_if.cpu_full !== 1'b0) begin n_fail++; $display("FAIL ovf_cnt3_full got=%b exp=0", sb_if.cpu_full); end
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (sb_if.mem_addr !== A'(8'h11 + i)) begin n_fail++; $display("FAIL ovf_drain_%0d got=%h exp=%h", i, sb_if.mem_addr, A'(8'h11 + i)); end
            cycle(1'b0, '0, '0, 1'b1);
        end
        n_checks++; if (sb_if.empty !== 1'b1) begin n_fail++; $display("FAIL ovf_empty got=%b exp=1", sb_if.empty); end
        n_checks++; if (sb_if.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got=%b exp=1", sb_if.overflow); end
    endtask

    task automatic test_streaming();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, A'(i), W'(32'h100 + i), 1'b1);
            n_checks++; if (sb_if.mem_valid !== 1'b1 || sb_if.mem_addr !== A'(i) || sb_if.mem_wdata !== W'(32'h100 + i)) begin
                n_fail++; $display("FAIL stream_%0d got=%b/%h/%h exp=1/%h/%h", i, sb_if.mem_valid, sb_if.mem_addr, sb_if.mem_wdata, A'(i), W'(32'h100 + i));
            end
            n_checks++; if (sb_if.cpu_full !== 1'b0) begin n_fail++; $display("FAIL stream_full_%0d got=%b exp=0", i, sb_if.cpu_full); end
        end
        cycle(1'b0, '0, '0, 1'b1);
        n_checks++; if (sb_if.empty !== 1'b1) begin n_fail++; $display("FAIL stream_empty got=%b exp=1", sb_if.empty); end
    endtask

    task automatic test_backpressure();
        logic [A-1:0] hd_a;
        logic [W-1:0] hd_d;
        bit           stall;
        logic         rdy;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            rdy   = (i % 2 == 0);
            hd_a  = sb_if.mem_addr;
            hd_d  = sb_if.mem_wdata;
            stall = sb_if.mem_valid && !rdy;
            cycle(1'b1, A'($urandom), $urandom, rdy);
            if (stall) begin
                n_checks++; if (sb_if.mem_addr !== hd_a || sb_if.mem_wdata !== hd_d) begin
                    n_fail++; $display("FAIL bp_stable_%0d got=%h/%h exp=%h/%h", i, sb_if.mem_addr, sb_if.mem_wdata, hd_a, hd_d);
                end
            end
            if (q.size() != 0) begin
                n_checks++; if (sb_if.mem_addr !== q[0].addr || sb_if.mem_wdata !== q[0].data) begin
                    n_fail++; $display("FAIL bp_head_%0d got=%h/%h exp=%h/%h", i, sb_if.mem_addr, sb_if.mem_wdata, q[0].addr, q[0].data);
                end
            end
            n_checks++; if (sb_if.cpu_full !== (q.size() == D) || sb_if.overflow !== m_ovf) begin
                n_fail++; $display("FAIL bp_flags_%0d got=%b/%b exp=%b/%b", i, sb_if.cpu_full, sb_if.overflow, q.size() == D, m_ovf);
            end
        end
    endtask

    task automatic test_forwarding();
        logic         exp_hit;
        logic [W-1:0] exp_data;
        do_reset();
        cycle(1'b1, 8'h30, 32'h1, 1'b0);
        cycle(1'b1, 8'h31, 32'h2, 1'b0);
        cycle(1'b1, 8'h30, 32'h3, 1'b0);
`ifdef STORE_BUF_FWD_EN
        exp_hit  = 1'b1;
        exp_data = 32'h3;
`else
        exp_hit  = 1'b0;
        exp_data = 32'h0;
`endif
        sb_if.fwd_addr = 8'h30;
        #1;
        n_checks++; if (sb_if.fwd_hit !== exp_hit || sb_if.fwd_data !== exp_data) begin
            n_fail++; $display("FAIL fwd_30 got=%b/%h exp=%b/%h", sb_if.fwd_hit, sb_if.fwd_data, exp_hit, exp_data);
        end
        sb_if.fwd_addr = 8'h40;
        #1;
        n_checks++; if (sb_if.fwd_hit !== 1'b0 || sb_if.fwd_data !== '0) begin
            n_fail++; $display("FAIL fwd_40 got=%b/%h exp=0/0", sb_if.fwd_hit, sb_if.fwd_data);
        end
    endtask

    task automatic test_random();
        logic         exp_hit;
        logic [W-1:0] exp_data;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, A'($urandom_range(0, 7)), $urandom, 1'($urandom_range(0, 1)));
            sb_if.fwd_addr = A'($urandom_range(0, 7));
            #1;
            exp_hit  = 1'b0;
            exp_data = '0;
`ifdef STORE_BUF_FWD_EN
            foreach (q[k]) begin
                if (q[k].addr == sb_if.fwd_addr) begin
                    exp_hit  = 1'b1;
                    exp_data = q[k].data;
                end
            end
`endif
            n_checks++; if (sb_if.empty !== (q.size() == 0) || sb_if.mem_valid !== (q.size() != 0) || sb_if.cpu_full !== (q.size() == D)) begin
                n_fail++; $display("FAIL rnd_flags_%0d got=%b/%b/%b cnt_exp=%0d", i, sb_if.empty, sb_if.mem_valid, sb_if.cpu_full, q.size());
            end
            n_checks++; if (sb_if.overflow !== m_ovf) begin n_fail++; $display("FAIL rnd_ovf_%0d got=%b exp=%b", i, sb_if.overflow, m_ovf); end
            if (q.size() != 0) begin
                n_checks++; if (sb_if.mem_addr !== q[0].addr || sb_if.mem_wdata !== q[0].data) begin
                    n_fail++; $display("FAIL rnd_head_%0d got=%h/%h exp=%h/%h", i, sb_if.mem_addr, sb_if.mem_wdata, q[0].addr, q[0].data);
                end
            end
            n_checks++; if (sb_if.fwd_hit !== exp_hit || sb_if.fwd_data !== exp_data) begin
                n_fail++; $display("FAIL rnd_fwd_%0d got=%b/%h exp=%b/%h", i, sb_if.fwd_hit, sb_if.fwd_data, exp_hit, exp_data);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_overflow();
        test_streaming();
        test_backpressure();
        test_forwarding();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
